if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage pipeline. It holds the program counter and drives it to the combinational instruction ROM. It captures the returned 32-bit instruction into the IF/ID pipeline register. It also handles freeze requests from the hazard unit and redirects from the ID-stage branch resolution, and it squashes the wrong-path fetch on a taken branch.

## Interface
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `NOP_WORD`, default 32'd0: instruction inserted into IF/ID on flush (all-zero word is NOP).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: hazard stall; hold PC and IF/ID contents.
- `branch_taken` in 1: ID resolved a taken branch/jump this cycle.
- `branch_addr` in 32: byte target address from ID.
- `instruction` in 32: ROM data for `pc`, combinational.
- `pc` out 32: current fetch address to ROM.
- `if_id_instruction` out 32: registered instruction.
- `if_id_pc` out 32: registered PC+4 of that instruction.
- `if_id_valid` out 1: IF/ID holds a real (non-squashed) instruction.
- `fetch_count` out 32: valid instructions delivered (see Configuration).
- `stall_count` out 32: freeze cycles honoured (see Configuration).

## Operation
- One clock; reset is synchronous and active-high.
- Per-edge priority: `rst` > `branch_taken` > `freeze` > normal.
- Reset: `pc`=RESET_PC, `if_id_instruction`=NOP_WORD, `if_id_pc`=0, `if_id_valid`=0, both counters 0.
- Normal: `pc` <= `pc`+4; IF/ID <= {`instruction`, `pc`+4, valid=1}.
- Freeze (no branch): `pc` and all IF/ID fields hold.
- Branch taken: `pc` <= {`branch_addr`[31:2], 2'b00}, and IF/ID <= {NOP_WORD, 0, valid=0}. This squashes the instruction fetched this cycle. A branch overrides a simultaneous `freeze`.
- `pc`+4 is modulo 2^32: 0xFFFFFFFC wraps to 0x00000000 with no flag.
- An undriven (z) ROM word is captured as-is; the block does no decoding.
- Reset asserted mid-freeze or mid-redirect: reset state wins on that edge, and fetch resumes at RESET_PC on the next edge.

## Timing
- `pc` is a register output, valid from the clock edge. ROM plus IF/ID setup must close in one cycle.
- Fetch latency is 1 cycle. The instruction at address A, presented in cycle n, appears on `if_id_instruction` after edge n+1.
- Branch penalty is 1 bubble from this stage: edge k takes the redirect and writes a NOP, and the target instruction appears after edge k+1.
- Freeze takes effect on the edge where it is sampled high. Release resumes with no lost or duplicated instruction.
- All outputs change only on `clk` rising edges.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `fetch_count` increments on each edge that loads IF/ID with valid=1.
  - `stall_count` increments on each edge where `freeze`=1 and `branch_taken`=0 and `rst`=0.
  - Both counters saturate at 0xFFFFFFFF and clear on `rst`.
- Not defined: counter registers are not built, and both ports are tied to 32'd0.

## Test plan
- Reset and stream: `rst` for 2 cycles, then release with ROM word 0 = 0x8001060A. After the first edge, `if_id_instruction`=0x8001060A, `if_id_pc`=4, `if_id_valid`=1, and `pc`=4.
- Freeze: with `pc`=12, hold `freeze` for 3 cycles. `pc` stays 12 and IF/ID is unchanged. After release, the word at 12 (0x04011000) is delivered exactly once; with IF_PERF_CNT_EN, `stall_count`=3.
- Branch: at `pc`=108, pulse `branch_taken` with `branch_addr`=0x00000173. Next state: `pc`=0x170, `if_id_valid`=0, `if_id_instruction`=0. One edge later, IF/ID holds the word at 0x170 with `if_id_pc`=0x174.
- Branch plus freeze together: assert `freeze`=1, `branch_taken`=1, `branch_addr`=0x184. Required result: `pc`=0x184 and IF/ID squashed, i.e. the branch wins.
- Wrap: force `pc` to 0xFFFFFFFC through a branch. The next edge gives `pc`=0 and `if_id_pc`=0.
- Reset mid-stream: assert `rst` while `freeze`=1 at `pc`=200. All outputs return to their reset values on that edge, and counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID capture, freeze hold and branch squash.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_WORD = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  logic [31:0] pc_plus4;
  logic        load_valid;
  logic        stall_cycle;

  // Wraps modulo 2^32 by construction
  assign pc_plus4    = pc + 32'd4;
  assign load_valid  = !rst && !branch_taken && !freeze;
  assign stall_cycle = !rst && !branch_taken && freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= RESET_PC;
      if_id_instruction <= NOP_WORD;
      if_id_pc          <= 32'd0;
      if_id_valid       <= 1'b0;
    end else if (branch_taken) begin
      pc                <= {branch_addr[31:2], 2'b00};
      if_id_instruction <= NOP_WORD;
      if_id_pc          <= 32'd0;
      if_id_valid       <= 1'b0;
    end else if (!freeze) begin
      pc                <= pc_plus4;
      if_id_instruction <= instruction;
      if_id_pc          <= pc_plus4;
      if_id_valid       <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (load_valid && (fetch_cnt != 32'hFFFF_FFFF))
        fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_cycle && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt;
  assign stall_count = stall_cnt;
`else
  logic unused_cnt;
  assign unused_cnt  = load_valid ^ stall_cycle;
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule
